light_timer_arbiter: RTL and testbench
======================================

# light_timer_arbiter

Shares one countdown interval timer among `N_REQ` traffic-light controllers, each of which drives the standard `t_start` / `t_length` / `t_done` / `t_flicker` timer handshake. Requests are queued per requester and granted round-robin. The granted interval runs to completion, then a one-cycle done pulse and a flicker pattern are steered back to the owning controller only. The block sits between the `traffic_light` instances of an intersection and replaces a per-light private timer.

## Interface
- `N_REQ`, 2, number of requesters (2..4)
- `LEN_W`, 5, interval length width
- `FLICK_WIN`, 4, final count values (count < `FLICK_WIN`) during which flicker is driven
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `req_start`  in  `N_REQ`  per-requester timer start strobe (`t_start`), sampled every edge
- `req_length`  in  `N_REQ*LEN_W`  packed lengths, requester i at bits [i*LEN_W +: LEN_W] (`t_length`)
- `req_done`  out  `N_REQ`  one-cycle interval-expired pulse to owner (`t_done`)
- `req_flicker`  out  `N_REQ`  flicker to owner (`t_flicker`)
- `pending`  out  `N_REQ`  queued-request flags
- `busy`  out  1  timer owned (state RUN or DONE)
- `owner`  out  `max(1,$clog2(N_REQ))`  index of current/last owner

## Operation
- Per requester: a pending flag and a length register `len_q[i]`. `req_start[i]` sampled high sets `pending[i]` and captures `req_length[i]` into `len_q[i]`. A repeat request while pending overwrites `len_q[i]` and does not double-queue.
- FSM states:
  - IDLE:
    - `pending` nonzero -> RUN.
    - winner = first set bit searching upward from `rr_ptr` with wrap.
    - `count` <= `len_q[winner]`, `owner` <= winner, `pending[winner]` cleared, `rr_ptr` <= winner+1 mod `N_REQ`.
  - RUN:
    - `count` != 0 -> decrement.
    - `count` == 0 -> DONE.
  - DONE:
    - `req_done[owner]` = 1 for exactly this cycle.
    - Unconditional transition -> IDLE. IDLE always lasts at least one cycle between grants.
- `req_flicker[owner]` = ~`count[0]` while in RUN with `count` < `FLICK_WIN`; 0 otherwise. All non-owner `req_flicker` and `req_done` bits are 0.
- Outputs are decodes of registered state, `count` and `owner` only, with no input-to-output combinational path.
- Length 0 is legal: RUN lasts one cycle.

## Timing
- Reset values: state IDLE, `count` 0, `rr_ptr` 0, `owner` 0, `pending` 0, `len_q` 0. Outputs after reset: `req_done` 0, `req_flicker` 0, `busy` 0.
- For request sampled at edge k, uncontended, length L:
  - grant at edge k+1;
  - RUN occupies L+1 cycles;
  - `req_done` high from edge k+L+2 to k+L+3.
- Back-to-back grants: second grant one edge after DONE ends (DONE -> IDLE -> RUN).
- `req_start[i]` at the same edge that grants i: the new request wins. `pending[i]` stays 1 with the new length, and the running interval uses the old `len_q`.
- Owner re-requesting during RUN/DONE is queued. It is never restarted or extended.
- Reset asserted mid-RUN: immediate return to reset values. No `req_done` pulse, and queued requests are lost.

## Configuration
- `LIGHT_ARB_FIXED_PRIO_EN` defined:
  - winner = lowest-index pending requester;
  - `rr_ptr` is not implemented;
  - `owner` still updates.
- Undefined: round-robin as described above (default).

## Test plan
- Reset values: hold `reset`=0 for 2 cycles -> all outputs 0, `pending`=0, state IDLE after release.
- Single request, length 3:
  - stimulus: `req_start[0]` at edge k.
  - grant at edge k+1, `busy` 1 from edge k+1.
  - `req_flicker[0]` pattern 0,1,0,1 over counts 3..0.
  - `req_done[0]` high only from edge k+5 to k+6; `req_done[1]` and `req_flicker[1]` stay 0.
- Round-robin, lengths 2 and 1:
  - stimulus: simultaneous `req_start`=2'b11 from reset.
  - requester 0 done first, then requester 1.
  - then issue another simultaneous request -> requester 0 wins again (`rr_ptr` wrapped to 0).
  - with `LIGHT_ARB_FIXED_PRIO_EN`: 0 always wins.
- Length 0: request at edge k -> `req_done` at edge k+2; `req_flicker` high for the single RUN cycle.
- Queued owner re-request:
  - stimulus: requester 0 running length 5; 0 re-requests length 2 and 1 requests length 4 during RUN.
  - first done (0) -> requester 1 granted next -> then requester 0 with length 2.
- Reset mid-run: pull `reset` low with count 3 and `pending[1]` set -> no `req_done` pulse ever, `pending`=0, `busy`=0 immediately.

Source files
------------

// File: rtl/light_timer_arbiter.sv
// Shares one countdown interval timer among N_REQ traffic-light controllers, round-robin.
// Define LIGHT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead.
module light_timer_arbiter #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned FLICK_WIN = 4,
  localparam int unsigned OwnerW   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_REQ-1:0]       req_start_i,
  input  logic [N_REQ*LEN_W-1:0] req_length_i,
  output logic [N_REQ-1:0]       req_done_o,
  output logic [N_REQ-1:0]       req_flicker_o,
  output logic [N_REQ-1:0]       pending_o,
  output logic                   busy_o,
  output logic [OwnerW-1:0]      owner_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [OwnerW-1:0]  owner_q, owner_d;
  logic [N_REQ-1:0]   pending_q, pending_d;
  logic [LEN_W-1:0]   len_q [N_REQ];
  logic [LEN_W-1:0]   len_d [N_REQ];

  logic [OwnerW-1:0]  winner;
  logic               any_pending;
  logic               grant;

  assign any_pending = |pending_q;
  assign grant       = (state_q == StIdle) && any_pending;

`ifdef LIGHT_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest-index pending requester is the last to assign.
  always_comb begin
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) winner = OwnerW'(i);
    end
  end
`else
  logic [OwnerW-1:0] rr_ptr_q, rr_ptr_d;
  logic [OwnerW-1:0] cand;
  logic              found;

  // First pending requester at or above rr_ptr_q, wrapping past N_REQ-1.
  always_comb begin
    winner = rr_ptr_q;
    cand   = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = OwnerW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found && pending_q[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      count_q   <= '0;
      owner_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < N_REQ; i++) len_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
      for (int i = 0; i < N_REQ; i++) len_q[i] <= len_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_pending) state_d = StRun;
      StRun:   if (count_q == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: a fresh strobe at the grant edge re-queues with the new length, while the
  // interval being granted still loads the old len_q.
  always_comb begin
    count_d   = count_q;
    owner_d   = owner_q;
    pending_d = pending_q;
    for (int i = 0; i < N_REQ; i++) len_d[i] = len_q[i];

    if (grant) begin
      count_d = len_q[winner];
      owner_d = winner;
    end else if ((state_q == StRun) && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end

    for (int i = 0; i < N_REQ; i++) begin
      if (req_start_i[i]) begin
        pending_d[i] = 1'b1;
        len_d[i]     = req_length_i[i*LEN_W +: LEN_W];
      end else if (grant && (winner == OwnerW'(i))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    req_done_o    = '0;
    req_flicker_o = '0;
    busy_o        = (state_q != StIdle);
    pending_o     = pending_q;
    owner_o       = owner_q;
    if (state_q == StDone) req_done_o[owner_q] = 1'b1;
    if ((state_q == StRun) && (32'(count_q) < FLICK_WIN)) begin
      req_flicker_o[owner_q] = ~count_q[0];
    end
  end

endmodule

// File: tb/tb_light_timer_arbiter.sv
// Bench for light_timer_arbiter: per-cycle vector table plus scoreboarded multi-grant sequences.
module tb_light_timer_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start;
  logic [9:0] length;
  logic [1:0] req_done, req_flicker, pending;
  logic       busy;
  logic       owner;

  always #5 clk = ~clk;

  light_timer_arbiter #(.N_REQ(2), .LEN_W(5), .FLICK_WIN(4)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_start_i  (start),
    .req_length_i (length),
    .req_done_o   (req_done),
    .req_flicker_o(req_flicker),
    .pending_o    (pending),
    .busy_o       (busy),
    .owner_o      (owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] start;
    logic [4:0] len0;
    logic [4:0] len1;
    logic [1:0] done;
    logic [1:0] flick;
    logic [1:0] pend;
    logic       busy;
    logic       own;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [1:0] s, logic [4:0] l0, logic [4:0] l1, logic [1:0] d,
                              logic [1:0] f, logic [1:0] p, logic b, logic o);
    vec_t v;
    v = '{start: s, len0: l0, len1: l1, done: d, flick: f, pend: p, busy: b, own: o};
    vecs.push_back(v);
  endfunction

  // Scoreboard of expected grants: owner index and programmed length.
  typedef struct {
    int own;
    int len;
  } exp_t;

  exp_t sb[$];
  bit   sb_en = 1'b0;
  int   run_cnt = 0;
  int   done_seen = 0;

  always @(negedge clk) begin
    exp_t e;
    if (req_done != 2'b00) done_seen++;
    if (sb_en) begin
      if (req_done != 2'b00) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done: got %b expected none", req_done);
        end else begin
          e = sb.pop_front();
          check("sb_done_owner", 32'(req_done), 32'(1) << e.own);
          check("sb_run_len", run_cnt, e.len + 1);
        end
      end
      if (busy && req_done == 2'b00) run_cnt++;
      else if (!busy) run_cnt = 0;
    end
  end

  task automatic wait_busy(string name);
    int n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 1);
  endtask

  initial begin
    exp_t e;
    int   n;
    start  = 2'b00;
    length = '0;

    // Single request len 3 from requester 0
    add(2'b01, 3, 0, 2'b00, 2'b00, 2'b01, 0, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    // Length 0 from requester 1
    add(2'b10, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0);
    add(2'b00, 0, 0, 2'b00, 2'b10, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    // Simultaneous requests, lengths 2 and 1
    add(2'b11, 2, 1, 2'b00, 2'b00, 2'b11, 0, 1);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b01, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b00, 2'b10, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    // Second simultaneous pair: requester 0 wins again
    add(2'b11, 1, 1, 2'b00, 2'b00, 2'b11, 0, 1);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b01, 2'b00, 2'b10, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 0, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b00, 2'b10, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 1, 1);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);
    // Re-request at the grant edge: old length runs, new one stays queued
    add(2'b01, 1, 0, 2'b00, 2'b00, 2'b01, 0, 1);
    add(2'b01, 3, 0, 2'b00, 2'b00, 2'b01, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 1, 0);
    add(2'b00, 0, 0, 2'b01, 2'b00, 2'b01, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b01, 0, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
    add(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_done", 32'(req_done), 0);
    check("rst_flick", 32'(req_flicker), 0);
    check("rst_pend", 32'(pending), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_pend", 32'(pending), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start  = vecs[i].start;
      length = {vecs[i].len1, vecs[i].len0};
      @(negedge clk);
      check($sformatf("v%0d_done", i), 32'(req_done), 32'(vecs[i].done));
      check($sformatf("v%0d_flick", i), 32'(req_flicker), 32'(vecs[i].flick));
      check($sformatf("v%0d_pend", i), 32'(pending), 32'(vecs[i].pend));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_owner", i), 32'(owner), 32'(vecs[i].own));
    end
    start = 2'b00;

    // Owner re-requests during its own run and is queued behind requester 1
    sb_en = 1'b1;
    start = 2'b01;
    length = {5'd0, 5'd5};
    e = '{own: 0, len: 5};
    sb.push_back(e);
    @(negedge clk);
    start = 2'b00;
    wait_busy("q_grant0");
    @(negedge clk);
    start = 2'b11;
    length = {5'd4, 5'd2};
`ifdef LIGHT_ARB_FIXED_PRIO_EN
    e = '{own: 0, len: 2};
    sb.push_back(e);
    e = '{own: 1, len: 4};
    sb.push_back(e);
`else
    e = '{own: 1, len: 4};
    sb.push_back(e);
    e = '{own: 0, len: 2};
    sb.push_back(e);
`endif
    @(negedge clk);
    start = 2'b00;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("q_drained", 32'(sb.size()), 0);
    repeat (5) @(negedge clk);
    sb_en = 1'b0;

    // Reset mid-run with requester 1 queued
    start = 2'b01;
    length = {5'd0, 5'd7};
    @(negedge clk);
    start = 2'b00;
    wait_busy("mr_grant");
    start = 2'b10;
    length = {5'd2, 5'd0};
    @(negedge clk);
    start = 2'b00;
    check("mr_pend1", 32'(pending), 32'(2'b10));
    repeat (3) @(negedge clk);
    check("mr_count3_busy", 32'(busy), 1);
    done_seen = 0;
    #1 rst_n = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_pend", 32'(pending), 0);
    check("mr_done", 32'(req_done), 0);
    check("mr_flick", 32'(req_flicker), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mr_no_done", done_seen, 0);
    check("mr_idle_busy", 32'(busy), 0);
    check("mr_idle_pend", 32'(pending), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
